dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised, clocked data memory for the 16-bit pipeline's MEM stage. Replaces the
//  combinational RAM with registered access and base+offset address generation.
//  Adds a valid/ready request port and a response port with backpressure, plus fault reporting.
//  Every accepted request returns exactly one response, in order.
// PARAMETERS
//  DATA_W  16  data and base-register width (bits); multiple of 8
//  ADDR_W  8   word-address width; depth = 2**ADDR_W words
//  OFFS_W  6   signed immediate offset width
//  RD_LAT  1   array-to-response pipeline stages; legal values 1 or 2
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  req_valid  in   1          request present
//  req_ready  out  1          request accepted when req_valid && req_ready
//  req_we     in   1          1 = write, 0 = read
//  base       in   DATA_W     base register value (rs)
//  offset     in   OFFS_W     signed offset (constant), sign-extended to DATA_W
//  wdata      in   DATA_W     write data
//  wstrb      in   DATA_W/8   byte-lane write enables; port exists only with DMEM_BYTE_LANE_EN
//  rsp_valid  out  1          response present
//  rsp_ready  in   1          response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_W     read data; 0 for writes and for faults
//  rsp_we     out  1          echo of req_we
//  rsp_fault  out  1          effective address out of range
// BEHAVIOUR
//  - Reset: synchronous, active-low. The registers below are sampled on clk when rst_n = 0.
//  - Reset values: rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_fault=0, req_ready=1 from the first cycle after reset.
//  - Array contents are not reset.
//  - Effective address: ea = base + sext(offset), modulo 2**DATA_W (wrap-around, no carry out).
//  - Fault when ea[DATA_W-1:ADDR_W] != 0. On fault: no array write, rdata forced to 0, rsp_fault=1.
//  - Write: the array is updated on the accept edge.
//  - Read: the array is sampled on the accept edge.
//  - Read-after-write: a read accepted in the cycle after a write to the same ea returns the new data.
//  - One request per cycle, so no same-cycle read/write conflict exists.
//  - Latency, accept to rsp_valid: exactly RD_LAT cycles when the response FIFO is empty and rsp_ready=1.
//  - Response FIFO: depth RD_LAT+1. It is written at the end of the pipeline. Head drives the rsp_* outputs.
//  - Response outputs are held stable while rsp_valid && !rsp_ready.
//  - Credit counter: resets to RD_LAT+1. It decrements on accept and increments on pop. Accept and pop in the same cycle leave it unchanged.
//  - req_ready = (credits != 0). The credit counter never exceeds RD_LAT+1 and never underflows.
//  - Full: credits = 0, so req_ready = 0. Requests are held off with no loss.
//  - Empty: rsp_valid = 0.
//  - Reset mid-operation: in-flight and queued responses are discarded, credits reload, and no partial write occurs.
// CONFIGURATION
//  DMEM_BYTE_LANE_EN defined: the wstrb port exists.
//   - Only lanes with wstrb[i]=1 are written.
//   - wstrb = 0 performs no write but still returns a response.
//  DMEM_BYTE_LANE_EN undefined: no wstrb port; every write updates the full word.
// STRUCTURE
//  - Shared package/include dmem_pkg holds:
//   - localparam LANES = DATA_W/8
//   - the response-entry field layout {fault, we, rdata}
//   - the RD_LAT legal-range check constant
//  - Sub-module dmem_rsp_fifo: parametrised depth/width synchronous FIFO.
//   - Signals: push, pop, full, empty.
//   - Same reset as the top level.
//  - Top level holds:
//   - the array
//   - the address adder
//   - the RD_LAT pipeline
//   - the credit counter
// TESTING
//  1. Reset, then write base=2 offset=1 wdata=16'h00AB, then read base=3 offset=0 -> rdata=16'h00AB, fault=0, rsp after RD_LAT cycles.
//  2. base=16'h0005 offset=6'b111011 (-5) write 16'h1234; read base=0 offset=0 -> 16'h1234 (negative offset reaches word 0).
//  3. base=16'h0100 offset=0 read (ADDR_W=8) -> rsp_fault=1, rdata=0. Write to the same ea -> fault=1 and word 16'h00 unchanged.
//  4. Hold rsp_ready=0 and issue back-to-back reads -> exactly RD_LAT+1 accepted, then req_ready=0.
//     Release rsp_ready -> all responses arrive in order with no drops or duplicates.
//  5. Read-after-write to the same address on consecutive cycles -> new data.
//     Assert rst_n=0 with 2 reads in flight -> no rsp_valid after reset, credits = RD_LAT+1.
//  6. With DMEM_BYTE_LANE_EN: word=16'hFFFF, write 16'h1200 with wstrb=2'b10 -> readback 16'h12FF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the MEM-stage data memory controller.
// Holds lane count, response-entry layout {fault, we, rdata} and RD_LAT legality check.
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int LANES = DMEM_DATA_W / 8;

    // Response entry is {fault, we, rdata}; metadata bits sit above rdata.
    localparam int RSP_META_W = 2;
    localparam int RSP_FAULT_POS = 1;
    localparam int RSP_WE_POS = 0;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_ok(int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic int rsp_w(int data_w);
        return data_w + RSP_META_W;
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO with synchronous active-low reset.
// Ports: clk, rst_n, push/din (only when !full), pop (only when !empty), dout (head), full, empty.
module dmem_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                store[wptr] <= din;
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = store[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_ctrl.sv
// Clocked MEM-stage data memory: base+offset addressing, fault check, RD_LAT pipeline,
// credit-controlled in-order response FIFO. Optional macro DMEM_BYTE_LANE_EN adds wstrb.
// Ports: clk, rst_n, req_valid/req_ready/req_we/base/offset/wdata[/wstrb],
//        rsp_valid/rsp_ready/rsp_rdata/rsp_we/rsp_fault.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = 8,
    parameter int OFFS_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W-1:0]   base,
    input  logic [OFFS_W-1:0]   offset,
    input  logic [DATA_W-1:0]   wdata,
`ifdef DMEM_BYTE_LANE_EN
    input  logic [DATA_W/8-1:0] wstrb,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_we,
    output logic                rsp_fault
);

    localparam int N_LANES = DATA_W / 8;
    localparam int DEPTH   = RD_LAT + 1;
    localparam int ENT_W   = rsp_w(DATA_W);
    localparam int CRD_W   = $clog2(DEPTH + 1);
    localparam bit LAT_OK  = rd_lat_ok(RD_LAT);

    if (!LAT_OK) begin : g_lat_chk
        $error("dmem_ctrl: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [DATA_W-1:0]  ea;
    logic [ADDR_W-1:0]  addr;
    logic               fault;
    logic               accept;
    logic               wr_en;
    logic [N_LANES-1:0] lane_en;
    logic [DATA_W-1:0]  rd_word;
    logic [ENT_W-1:0]   acc_ent;
    logic               push;
    logic [ENT_W-1:0]   push_ent;
    logic               pop;
    logic [ENT_W-1:0]   head;
    logic               full;
    logic               empty;
    logic [CRD_W-1:0]   credits;

    // Wrap-around add; carry out of DATA_W is dropped.
    assign ea    = base + {{(DATA_W - OFFS_W){offset[OFFS_W-1]}}, offset};
    assign addr  = ea[ADDR_W-1:0];
    assign fault = |ea[DATA_W-1:ADDR_W];

    assign req_ready = (credits != '0);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && !fault;

`ifdef DMEM_BYTE_LANE_EN
    assign lane_en = wstrb;
`else
    assign lane_en = '1;
`endif

    // Array is not reset, but writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (lane_en[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Combinational read; the FIFO or stage register captures it on the accept edge,
    // so a read right after a write to the same word sees the new value.
    assign rd_word = (fault || req_we) ? '0 : mem[addr];
    assign acc_ent = {fault, req_we, rd_word};

    if (RD_LAT == 2) begin : g_lat2
        logic             s_v;
        logic [ENT_W-1:0] s_ent;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_v   <= 1'b0;
                s_ent <= '0;
            end else begin
                s_v <= accept;
                if (accept) begin
                    s_ent <= acc_ent;
                end
            end
        end

        assign push     = s_v;
        assign push_ent = s_ent;
    end else begin : g_lat1
        assign push     = accept;
        assign push_ent = acc_ent;
    end

    dmem_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push && !full),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign rsp_valid = !empty;
    assign pop       = rsp_valid && rsp_ready;
    assign {rsp_fault, rsp_we, rsp_rdata} = empty ? '0 : head;

    // One credit per FIFO slot; an accept reserves a slot, a pop frees it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= CRD_W'(DEPTH);
        end else begin
            credits <= credits - CRD_W'(accept) + CRD_W'(pop);
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: random and directed requests, reference memory model.
// Build with DMEM_BYTE_LANE_EN defined to also exercise byte-lane writes.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] base;
    logic [5:0]  offset;
    logic [15:0] wdata;
`ifdef DMEM_BYTE_LANE_EN
    logic [LANES-1:0] wstrb;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_we;
    logic        rsp_fault;

    dmem_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .OFFS_W (6),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .base      (base),
        .offset    (offset),
        .wdata     (wdata),
`ifdef DMEM_BYTE_LANE_EN
        .wstrb     (wstrb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_we    (rsp_we),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [15:0] rdata;
        logic        we;
        logic        fault;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mdl [256];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          rdy_mode = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: ea is a plain 16-bit sum; anything above 255 is out of range.
    function automatic exp_t model(bit we, logic [15:0] b, logic [5:0] off,
                                   logic [15:0] wd, logic [1:0] st);
        exp_t e;
        int   ea;
        int   soff;
        soff = off[5] ? int'(off) - 64 : int'(off);
        ea = (int'(b) + soff) & 16'hFFFF;
        e.fault = (ea > 255);
        e.we = we;
        e.rdata = 16'h0;
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        if (we && !e.fault) begin
            if (st[0]) mdl[ea][7:0] = wd[7:0];
            if (st[1]) mdl[ea][15:8] = wd[15:8];
        end
        if (!we && !e.fault) e.rdata = mdl[ea];
        return e;
    endfunction

    // Monitor: drives rsp_ready, pops and compares on each handshake.
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out;
    always @(negedge clk) begin
        exp_t e;
        if (rdy_mode == 0) rsp_ready = 1'b1;
        else if (rdy_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
        else rsp_ready = 1'b0;
        if (mon_en) begin
            if (prev_stall)
                check("hold", {rsp_valid, rsp_fault, rsp_we, rsp_rdata}, {1'b1, prev_out});
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("rdata", rsp_rdata, e.rdata);
                    check("fault", rsp_fault, e.fault);
                    check("we", rsp_we, e.we);
                    if (e.chk_lat) check("latency", cyc - e.acc_cyc, RD_LAT);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
        end else begin
            prev_stall = 1'b0;
        end
        prev_out = {rsp_fault, rsp_we, rsp_rdata};
    end

    task automatic try_send(bit we, logic [15:0] b, logic [5:0] off, logic [15:0] wd,
                            logic [1:0] st, bit cl, output bit acc);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        base = b;
        offset = off;
        wdata = wd;
`ifdef DMEM_BYTE_LANE_EN
        wstrb = st;
`endif
        acc = req_ready;
        if (acc) begin
`ifdef DMEM_BYTE_LANE_EN
            e = model(we, b, off, wd, st);
`else
            e = model(we, b, off, wd, 2'b11);
`endif
            e.acc_cyc = cyc;
            e.chk_lat = cl;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send(bit we, logic [15:0] b, logic [5:0] off, logic [15:0] wd,
                        logic [1:0] st, bit cl);
        bit acc = 1'b0;
        int n = 0;
        while (!acc) begin
            try_send(we, b, off, wd, st, cl, acc);
            n++;
            if (!acc && n > 100) begin
                check("req_ready_timeout", 32'(acc), 32'h1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic stall_test(string tag);
        int nacc = 0;
        bit acc;
        rdy_mode = 2;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            try_send(1'b0, 16'($urandom_range(0, 255)), 6'h0, 16'h0, 2'b11, 1'b0, acc);
            if (acc) nacc++;
        end
        check({tag, "_accepted"}, nacc, RD_LAT + 1);
        @(negedge clk);
        check({tag, "_ready_low"}, 32'(req_ready), 32'h0);
        rdy_mode = 0;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] b;
        bit acc;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        base = '0;
        offset = '0;
        wdata = '0;
`ifdef DMEM_BYTE_LANE_EN
        wstrb = '0;
`endif
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_we", 32'(rsp_we), 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        mon_en = 1'b1;

        for (int a = 0; a < 256; a++)
            send(1'b1, 16'(a), 6'h0, 16'($urandom), 2'b11, 1'b0);
        drain();

        send(1'b1, 16'h0002, 6'd1, 16'h00AB, 2'b11, 1'b0);
        drain();
        send(1'b0, 16'h0003, 6'd0, 16'h0, 2'b11, 1'b1);
        drain();

        send(1'b1, 16'h0005, 6'b111011, 16'h1234, 2'b11, 1'b0);
        drain();
        send(1'b0, 16'h0000, 6'd0, 16'h0, 2'b11, 1'b1);
        drain();

        send(1'b0, 16'h0100, 6'd0, 16'h0, 2'b11, 1'b1);
        send(1'b1, 16'h0100, 6'd0, 16'hBEEF, 2'b11, 1'b0);
        send(1'b0, 16'h0000, 6'd0, 16'h0, 2'b11, 1'b0);
        send(1'b0, 16'h0000, 6'b111111, 16'h0, 2'b11, 1'b0);
        send(1'b0, 16'h00FF, 6'd1, 16'h0, 2'b11, 1'b0);
        drain();

        stall_test("stall");

        send(1'b1, 16'h0007, 6'd0, 16'h5A5A, 2'b11, 1'b0);
        send(1'b0, 16'h0007, 6'd0, 16'h0, 2'b11, 1'b0);
        send(1'b1, 16'h0008, 6'd2, 16'hC3C3, 2'b11, 1'b0);
        send(1'b0, 16'h000A, 6'd0, 16'h0, 2'b11, 1'b0);
        drain();

        mon_en = 1'b0;
        rdy_mode = 2;
        try_send(1'b0, 16'h0011, 6'd0, 16'h0, 2'b11, 1'b0, acc);
        try_send(1'b0, 16'h0012, 6'd0, 16'h0, 2'b11, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b1;
        base = 16'h0009;
        offset = 6'd0;
        wdata = ~mdl[9];
`ifdef DMEM_BYTE_LANE_EN
        wstrb = 2'b11;
`endif
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b1;
        sbq.delete();
        rdy_mode = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(rsp_valid), 32'h0);
            check("post_rst_ready", 32'(req_ready), 32'h1);
        end
        stall_test("post_rst");
        send(1'b0, 16'h0009, 6'd0, 16'h0, 2'b11, 1'b1);
        drain();

`ifdef DMEM_BYTE_LANE_EN
        send(1'b1, 16'h0014, 6'd0, 16'hFFFF, 2'b11, 1'b0);
        send(1'b1, 16'h0014, 6'd0, 16'h1200, 2'b10, 1'b0);
        send(1'b0, 16'h0014, 6'd0, 16'h0, 2'b11, 1'b0);
        send(1'b1, 16'h0014, 6'd0, 16'h0000, 2'b00, 1'b0);
        send(1'b0, 16'h0014, 6'd0, 16'h0, 2'b11, 1'b0);
        send(1'b1, 16'h0015, 6'd0, 16'hABCD, 2'b01, 1'b0);
        send(1'b0, 16'h0015, 6'd0, 16'h0, 2'b11, 1'b0);
        drain();
`endif

        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) != 0) b = {8'h00, 8'($urandom)};
            else b = 16'($urandom);
            send(1'($urandom_range(0, 1)), b, 6'($urandom), 16'($urandom),
                 2'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
